// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the 16x16 multi-cycle multiplier sequencer.
// Holds the sequencer state encoding, the partial-product index constants,
// the per-index alignment shift and the 16-bit magnitude helper.
package mult_seq_pkg;

   localparam int OP_W   = 16;
   localparam int PROD_W = 32;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } seqState_t;

   // Partial-product order: aL*bL, aL*bH, aH*bL, aH*bH
   localparam logic [1:0] IDX_LL = 2'd0;
   localparam logic [1:0] IDX_LH = 2'd1;
   localparam logic [1:0] IDX_HL = 2'd2;
   localparam logic [1:0] IDX_HH = 2'd3;

   // Shift table indexed by partial-product index: 0, 8, 8, 16
   function automatic logic [PROD_W-1:0] alignPartial(input logic [2*BYTE_W-1:0] pp,
                                                      input logic [1:0] idx);
      logic [PROD_W-1:0] ext;
      ext = {{(PROD_W-2*BYTE_W){1'b0}}, pp};
      case (idx)
         IDX_LL:  alignPartial = ext;
         IDX_LH:  alignPartial = ext << 8;
         IDX_HL:  alignPartial = ext << 8;
         default: alignPartial = ext << 16;
      endcase
   endfunction

   // 0x8000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [OP_W-1:0] absVal(input logic [OP_W-1:0] x);
      absVal = x[OP_W-1] ? (~x + 16'd1) : x;
   endfunction

endpackage

// File: rtl/multiplier_8bit.sv
// 8x8 combinational multiplier array shared by the ALU.
// Ports:
//   a, b      8-bit operands
//   multMode  0 = unsigned, 1 = signed two's complement
//   p         16-bit product
module multiplier_8bit
   import mult_seq_pkg::*;
(
   input  logic [BYTE_W-1:0]   a,
   input  logic [BYTE_W-1:0]   b,
   input  logic                multMode,
   output logic [2*BYTE_W-1:0] p
);

   logic [2*BYTE_W-1:0] aExt;
   logic [2*BYTE_W-1:0] bExt;

   always_comb begin
      aExt = {{BYTE_W{multMode & a[BYTE_W-1]}}, a};
      bExt = {{BYTE_W{multMode & b[BYTE_W-1]}}, b};
      // Low 16 bits of the sign/zero-extended product are the same for
      // signed and unsigned interpretation, so one unsigned multiply serves.
      p    = aExt * bExt;
   end

endmodule

// File: rtl/mult16_sequencer.sv
// 16x16 multi-cycle multiplier controller. Time-shares one multiplier_8bit
// across four unsigned partial products of the operand magnitudes, then
// applies the sign at the end.
// Ports:
//   clk, rst            clock, async active-high reset
//   inValid / inReady   operand handshake (A, B, multMode sampled on accept)
//   A, B                16-bit operands
//   multMode            0 = unsigned, 1 = signed
//   outValid / outReady product handshake
//   P                   32-bit product, held until the next FIX->DONE edge
//
// state | meaning
// IDLE  | waiting for operands, inReady high
// MUL   | accumulating partial product idx 0..3, one per cycle
// FIX   | applying sign correction into P
// DONE  | P valid, waiting for consumer
module mult16_sequencer
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inValid,
   output logic               inReady,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic               multMode,
   output logic               outValid,
   input  logic               outReady,
   output logic [2*WIDTH-1:0] P
);

   seqState_t state;
   seqState_t stateNext;

   logic [OP_W-1:0]     aMag;
   logic [OP_W-1:0]     bMag;
   logic                negRes;
   logic [PROD_W-1:0]   acc;
   logic [1:0]          idx;

   logic                accept;
   logic                accumulate;
   logic                loadP;

   logic [BYTE_W-1:0]   aByte;
   logic [BYTE_W-1:0]   bByte;
   logic [2*BYTE_W-1:0] partial;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (inValid)      stateNext = MUL;
         MUL:  if (idx == IDX_HH) stateNext = FIX;
         FIX:                    stateNext = DONE;
         DONE: if (outReady)     stateNext = IDLE;
         default:                stateNext = IDLE;
      endcase
   end

   // Output / strobe logic; inReady is masked by rst so it is low while
   // reset is held even though the state already reads IDLE.
   always_comb begin
      inReady    = (state == IDLE) && !rst;
      outValid   = (state == DONE);
      accept     = inValid && inReady;
      accumulate = (state == MUL);
      loadP      = (state == FIX);
   end

   // idx selects the operand bytes: bit 1 picks the A half, bit 0 the B half.
   always_comb begin
      aByte = idx[1] ? aMag[OP_W-1:BYTE_W] : aMag[BYTE_W-1:0];
      bByte = idx[0] ? bMag[OP_W-1:BYTE_W] : bMag[BYTE_W-1:0];
   end

   multiplier_8bit uMult (
      .a        (aByte),
      .b        (bByte),
      .multMode (1'b0),
      .p        (partial)
   );

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aMag   <= '0;
         bMag   <= '0;
         negRes <= 1'b0;
         acc    <= '0;
         idx    <= '0;
         P      <= '0;
      end else begin
         if (accept) begin
            aMag   <= multMode ? absVal(A) : A;
            bMag   <= multMode ? absVal(B) : B;
            negRes <= multMode & (A[OP_W-1] ^ B[OP_W-1]);
            acc    <= '0;
            idx    <= IDX_LL;
         end
         if (accumulate) begin
            acc <= acc + alignPartial(partial, idx);
            idx <= idx + 2'd1;
         end
         if (loadP) begin
            P <= negRes ? (~acc + 32'd1) : acc;
         end
      end
   end

endmodule

// File: tb/tb_mult16_sequencer.sv
module tb_mult16_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        multMode = 1'b0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] P;

   int checks = 0;
   int errors = 0;

   mult16_sequencer #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReady),
      .A        (A),
      .B        (B),
      .multMode (multMode),
      .outValid (outValid),
      .outReady (outReady),
      .P        (P)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitInReady(input string tag);
      int n = 0;
      while (!inReady && n < 20) begin
         tick();
         n++;
      end
      checkVal({tag, " inReady wait"}, {31'b0, inReady}, 32'd1);
   endtask

   task automatic waitOutValid(input string tag, input logic [31:0] expP);
      int n = 0;
      while (!outValid && n < 20) begin
         tick();
         n++;
      end
      checkVal({tag, " latency"}, n, 32'd5);
      checkVal({tag, " product"}, P, expP);
   endtask

   task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic mode,
                        input int stall, input logic [31:0] expP, input string tag);
      waitInReady(tag);
      A = a; B = b; multMode = mode; inValid = 1'b1;
      tick();
      inValid = 1'b0;
      waitOutValid(tag, expP);
      outReady = 1'b0;
      for (int i = 0; i < stall; i++) begin
         tick();
         checkVal({tag, " stall P"}, P, expP);
         checkVal({tag, " stall inReady"}, {31'b0, inReady}, 32'd0);
      end
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkVal({tag, " outValid drop"}, {31'b0, outValid}, 32'd0);
      checkVal({tag, " inReady back"}, {31'b0, inReady}, 32'd1);
      checkVal({tag, " P kept"}, P, expP);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb;
      logic        rm;
      longint      sa, sb, prod;

      #2;
      checkVal("reset inReady", {31'b0, inReady}, 32'd0);
      checkVal("reset outValid", {31'b0, outValid}, 32'd0);
      checkVal("reset P", P, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkVal("release inReady", {31'b0, inReady}, 32'd1);

      runOp(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, "u ffff*ffff");
      runOp(16'h8000, 16'h8000, 1'b1, 0, 32'h40000000, "s 8000*8000");
      runOp(16'hFFFF, 16'h0003, 1'b1, 0, 32'hFFFFFFFD, "s ffff*0003");
      runOp(16'hFFFF, 16'h0003, 1'b0, 0, 32'h0002FFFD, "u ffff*0003");
      runOp(16'h1234, 16'h0000, 1'b1, 0, 32'h00000000, "s 1234*0000");
      runOp(16'h8000, 16'h7FFF, 1'b1, 1, 32'hC0008000, "s 8000*7fff");

      // Backpressure with new operands presented while busy
      waitInReady("bp");
      A = 16'h1234; B = 16'h0002; multMode = 1'b0; inValid = 1'b1;
      tick();
      A = 16'h0003; B = 16'h0005;
      waitOutValid("bp first", 32'h00002468);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkVal("bp hold P", P, 32'h00002468);
         checkVal("bp hold inReady", {31'b0, inReady}, 32'd0);
         checkVal("bp hold outValid", {31'b0, outValid}, 32'd1);
      end
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkVal("bp idle inReady", {31'b0, inReady}, 32'd1);
      checkVal("bp idle P", P, 32'h00002468);
      tick();
      inValid = 1'b0;
      checkVal("bp accepted", {31'b0, inReady}, 32'd0);
      waitOutValid("bp second", 32'h0000000F);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;

      // Reset while in MUL idx2
      waitInReady("rst");
      A = 16'h1234; B = 16'h5678; multMode = 1'b0; inValid = 1'b1;
      tick();
      inValid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checkVal("midrst outValid", {31'b0, outValid}, 32'd0);
      checkVal("midrst P", P, 32'd0);
      checkVal("midrst inReady", {31'b0, inReady}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      checkVal("midrst release inReady", {31'b0, inReady}, 32'd1);
      runOp(16'h00FF, 16'h0101, 1'b0, 0, 32'h0000FFFF, "after rst");

      // Random pairs against a native-arithmetic reference
      for (int k = 0; k < 200; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rm = 1'($urandom);
         if (rm) begin
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
         end else begin
            sa = longint'(ra);
            sb = longint'(rb);
         end
         prod = sa * sb;
         runOp(ra, rb, rm, int'($urandom_range(0, 3)), prod[31:0], "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
